// File: rtl/resp_checker_if.sv
// rtl/resp_checker_if.sv - golden/netlist sample handshake bundle for resp_checker
interface resp_checker_if #(
  parameter int DATA_W = 8
) ();
  logic              gold_valid;
  logic [DATA_W-1:0] gold_data;
  logic              gold_ready;
  logic              net_valid;
  logic [DATA_W-1:0] net_data;
  logic              net_ready;

  modport master (
    output gold_valid, gold_data, net_valid, net_data,
    input  gold_ready, net_ready
  );

  modport slave (
    input  gold_valid, gold_data, net_valid, net_data,
    output gold_ready, net_ready
  );
endinterface

// File: rtl/resp_checker.sv
// rtl/resp_checker.sv - compares paired golden/netlist samples under a mask
// and reports counts, pass/fail and the first mismatching sample.
module resp_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [DATA_W-1:0] cmp_mask,
  resp_checker_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              err_valid,
  output logic [CNT_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_gold,
  output logic [DATA_W-1:0] err_net
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_num;
  logic [DATA_W-1:0] r_mask;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [CNT_W-1:0]  r_mismatch_cnt;
  logic              r_err_valid;
  logic [CNT_W-1:0]  r_err_idx;
  logic [DATA_W-1:0] r_err_gold;
  logic [DATA_W-1:0] r_err_net;

  logic              w_start_acc;
  logic              w_xfer;
  logic              w_mis;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_start_acc = start && (r_state != RUN);
  // Both sides are consumed together or not at all.
  assign w_xfer      = (r_state == RUN) && bus.gold_valid && bus.net_valid;
  assign w_mis       = |((bus.gold_data ^ bus.net_data) & r_mask);
  assign w_cnt_next  = r_sample_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_xfer && (w_cnt_next == r_num)) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num          <= '0;
      r_mask         <= '0;
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_err_valid    <= 1'b0;
      r_err_idx      <= '0;
      r_err_gold     <= '0;
      r_err_net      <= '0;
    end else if (w_start_acc) begin
      r_num          <= num_samples;
      r_mask         <= cmp_mask;
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_err_valid    <= 1'b0;
      r_err_idx      <= '0;
      r_err_gold     <= '0;
      r_err_net      <= '0;
    end else if (w_xfer) begin
      r_sample_cnt <= w_cnt_next;
      if (w_mis) begin
        if (r_mismatch_cnt != '1) begin
          r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
        end
        // Only the first mismatch of a run is recorded.
        if (!r_err_valid) begin
          r_err_valid <= 1'b1;
          r_err_idx   <= r_sample_cnt;
          r_err_gold  <= bus.gold_data;
          r_err_net   <= bus.net_data;
        end
      end
    end
  end

  assign bus.gold_ready = w_xfer;
  assign bus.net_ready  = w_xfer;
  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign pass           = (r_state == DONE) && (r_mismatch_cnt == '0);
  assign sample_cnt     = r_sample_cnt;
  assign mismatch_cnt   = r_mismatch_cnt;
  assign err_valid      = r_err_valid;
  assign err_idx        = r_err_idx;
  assign err_gold       = r_err_gold;
  assign err_net        = r_err_net;

endmodule

// File: tb/tb_resp_checker.sv
// tb/tb_resp_checker.sv - randomized self-checking bench for resp_checker
module tb_resp_checker;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_samples;
  logic [DATA_W-1:0] cmp_mask;
  logic              busy, done, pass, err_valid;
  logic [CNT_W-1:0]  sample_cnt, mismatch_cnt, err_idx;
  logic [DATA_W-1:0] err_gold, err_net;

  resp_checker_if #(.DATA_W(DATA_W)) bus ();

  resp_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .cmp_mask(cmp_mask), .bus(bus), .busy(busy), .done(done), .pass(pass),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .err_valid(err_valid),
    .err_idx(err_idx), .err_gold(err_gold), .err_net(err_net)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] gq[$];
  logic [DATA_W-1:0] nq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int num, input logic [DATA_W-1:0] mask);
    @(negedge clk);
    start = 1'b1; num_samples = num[CNT_W-1:0]; cmp_mask = mask;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents gq/nq pairs, with random one-sided stalls when stall=1.
  task automatic drive_pairs(input bit stall);
    int i = 0;
    int cyc = 0;
    logic gv, nv;
    while (i < gq.size() && cyc < 20000) begin
      @(negedge clk);
      gv = !stall || ($urandom_range(0, 3) != 0);
      nv = !stall || ($urandom_range(0, 3) != 0);
      bus.gold_valid = gv; bus.net_valid = nv;
      bus.gold_data = gq[i]; bus.net_data = nq[i];
      #1;
      check_eq("ready_pair", {30'd0, bus.gold_ready, bus.net_ready}, {30'd0, gv & nv, gv & nv});
      if (bus.gold_ready) i++;
      cyc++;
    end
    @(negedge clk);
    bus.gold_valid = 1'b0; bus.net_valid = 1'b0;
    if (i < gq.size()) check_eq("drive_timeout", i, gq.size());
  endtask

  // Reference outcome of a completed run, straight from the comparison rules.
  task automatic check_result(input string tag, input logic [DATA_W-1:0] mask);
    int mis = 0;
    int first = -1;
    foreach (gq[k]) begin
      if (((gq[k] ^ nq[k]) & mask) != 0) begin
        if (first < 0) first = k;
        mis++;
      end
    end
    #1;
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_cnt"}, sample_cnt, gq.size());
    check_eq({tag, "_mis"}, mismatch_cnt, (mis > 65535) ? 65535 : mis);
    check_eq({tag, "_pass"}, pass, (mis == 0) ? 1 : 0);
    check_eq({tag, "_errv"}, err_valid, (first >= 0) ? 1 : 0);
    check_eq({tag, "_eidx"}, err_idx, (first >= 0) ? first : 0);
    check_eq({tag, "_egold"}, err_gold, (first >= 0) ? gq[first] : 0);
    check_eq({tag, "_enet"}, err_net, (first >= 0) ? nq[first] : 0);
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    check_eq({tag, "_flags"}, {busy, done, pass, err_valid, bus.gold_ready, bus.net_ready}, 0);
    check_eq({tag, "_counts"}, {sample_cnt, mismatch_cnt}, 0);
    check_eq({tag, "_rec"}, {err_idx, err_gold, err_net}, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] g;
    rst_n = 1'b0; start = 1'b0; num_samples = '0; cmp_mask = '0;
    bus.gold_valid = 1'b0; bus.net_valid = 1'b0; bus.gold_data = '0; bus.net_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Four equal pairs
    gq = '{8'h00, 8'h01, 8'h02, 8'h03}; nq = '{8'h00, 8'h01, 8'h02, 8'h03};
    do_start(4, 8'hFF);
    #1 check_eq("run_busy", busy, 1);
    drive_pairs(0);
    check_result("eq4", 8'hFF);

    // Two mismatches, first at index 1
    gq = '{8'h05, 8'h0A, 8'h0C}; nq = '{8'h05, 8'h0B, 8'h0D};
    do_start(3, 8'hFF);
    drive_pairs(1);
    check_result("mis3", 8'hFF);
    check_eq("mis3_idx_abs", err_idx, 1);
    // Samples offered in DONE must be ignored
    bus.gold_valid = 1'b1; bus.net_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("done_noready", bus.gold_ready | bus.net_ready, 0);
    end
    bus.gold_valid = 1'b0; bus.net_valid = 1'b0;
    check_result("mis3_hold", 8'hFF);

    // Masked LSB difference, plus one-sided stall
    do_start(1, 8'hFE);
    bus.gold_valid = 1'b1; bus.net_valid = 1'b0; bus.gold_data = 8'h04; bus.net_data = 8'h05;
    repeat (5) begin
      @(negedge clk); #1;
      check_eq("stall_ready", {bus.gold_ready, bus.net_ready}, 0);
      check_eq("stall_cnt", sample_cnt, 0);
    end
    gq = '{8'h04}; nq = '{8'h05};
    drive_pairs(0);
    check_result("mask", 8'hFE);

    // Zero-length run
    @(negedge clk);
    start = 1'b1; num_samples = '0; cmp_mask = 8'hFF;
    #1 check_eq("zero_busy0", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("zero_done", done, 1);
    check_eq("zero_pass", pass, 1);
    check_eq("zero_busy1", busy, 0);
    check_eq("zero_cnt", sample_cnt, 0);

    // Reset in the middle of a run
    gq = '{8'h11, 8'h22}; nq = '{8'h11, 8'h23};
    do_start(6, 8'hFF);
    drive_pairs(0);
    #1 check_eq("midrun_cnt", sample_cnt, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_rst");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("post_rst_idle", {busy, done, pass}, 0);
    end
    gq = '{8'h33, 8'h44}; nq = '{8'h33, 8'h44};
    do_start(2, 8'hFF);
    drive_pairs(1);
    check_result("fresh2", 8'hFF);

    // Random run
    gq.delete(); nq.delete();
    m = $urandom_range(0, 255);
    for (int i = 0; i < 500; i++) begin
      g = $urandom_range(0, 255);
      gq.push_back(g);
      nq.push_back(($urandom_range(0, 3) == 0) ? (g ^ 8'($urandom_range(1, 255))) : g);
    end
    do_start(500, m);
    drive_pairs(1);
    check_result("rand500", m);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
